// File: rtl/icache_axi_rd_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_axi_rd_bridge_pkg                                     |
// | Description : Shared constants for the I-cache AXI read bridge: FSM state  |
// |               encodings, AXI4 size/burst/response codes, reset polarity.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package icache_axi_rd_bridge_pkg;

    // Reset is active-high.
    localparam logic RST_ENABLE = 1'b1;

    // Bridge FSM state encoding.
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AR    = 2'd1;
    localparam logic [1:0] ST_R     = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // AXI4 encodings.
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage : icache_axi_rd_bridge_pkg
`default_nettype wire

// File: rtl/icache_axi_rd_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_axi_rd_bridge                                         |
// | Description : Turns one I-cache line-refill request into a single AXI4     |
// |               read burst and streams the beats back to the cache with a    |
// |               locally generated last flag, beat index and sticky error.    |
// |               A flush during a refill drains the burst silently.           |
// | Options     : ICACHE_BRIDGE_WRAP_EN - critical-word-first WRAP bursts.     |
// | Ports       : clk/rst      clock, async active-high reset                  |
// |               flush        abandon the current refill                      |
// |               c_ar*        refill request from the cache                   |
// |               c_r*         refill beats to the cache                       |
// |               err          sticky protocol/response error                  |
// |               ar*/r*       AXI4 read address / read data channels          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    // cache side
    input  logic [31:0]                   c_araddr,
    input  logic                          c_arvalid,
    output logic                          c_arready,
    output logic [31:0]                   c_rdata,
    output logic                          c_rvalid,
    output logic                          c_rlast,
    output logic [$clog2(LINE_WORDS)-1:0] c_rindex,
    input  logic                          c_rready,
    output logic                          err,
    // AXI read address channel
    output logic [3:0]                    arid,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    // AXI read data channel
    input  logic [3:0]                    rid,
    input  logic [31:0]                   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int                OFFS_W   = $clog2(LINE_WORDS) + 2;
    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [31:0]      r_araddr;
    logic [IDX_W-1:0] r_cnt;
    logic             r_drop;
    logic             r_err;

    logic             w_accept;
    logic             w_rhs;
    logic             w_last;
    logic             w_bad_beat;
    logic [31:0]      w_araddr_load;
    logic [IDX_W-1:0] w_cnt_load;

`ifdef ICACHE_BRIDGE_WRAP_EN
    // The word index starts at the critical word, so termination and rlast
    // checking need their own 0-based beat counter.
    logic [IDX_W-1:0] r_beat;
    logic [1:0]       w_unused_addr;

    assign w_araddr_load = {c_araddr[31:2], 2'b00};
    assign w_cnt_load    = c_araddr[OFFS_W-1:2];
    assign w_last        = (r_beat == LAST_IDX);
    assign arburst       = BURST_WRAP;
    assign w_unused_addr = c_araddr[1:0];
`else
    logic [OFFS_W-1:0] w_unused_addr;

    assign w_araddr_load = {c_araddr[31:OFFS_W], {OFFS_W{1'b0}}};
    assign w_cnt_load    = '0;
    assign w_last        = (r_cnt == LAST_IDX);
    assign arburst       = BURST_INCR;
    assign w_unused_addr = c_araddr[OFFS_W-1:0];
`endif

    // Static AR fields and R-channel data pass-through.
    assign arid     = AXI_ID;
    assign araddr   = r_araddr;
    assign arlen    = 8'(LINE_WORDS - 1);
    assign arsize   = SIZE_4B;
    assign c_rdata  = rdata;
    assign c_rindex = r_cnt;
    assign err      = r_err;

    assign w_rhs      = rvalid && rready;
    assign w_bad_beat = (rresp != RESP_OKAY) || (rid != AXI_ID) || (rlast != w_last);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        c_arready   = 1'b0;
        arvalid     = 1'b0;
        c_rvalid    = 1'b0;
        c_rlast     = 1'b0;
        rready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                c_arready = 1'b1;
                if (c_arvalid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                // AR cannot be withdrawn once raised; a flush here only
                // redirects the burst into DRAIN after the handshake.
                arvalid = 1'b1;
                if (arready) begin
                    w_state_nxt = (r_drop || flush) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                rready   = c_rready;
                c_rvalid = rvalid && !flush;
                c_rlast  = w_last;
                // Last beat wins over flush: nothing is left to drain.
                if (rvalid && c_rready && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rready = 1'b1;
                if (rvalid && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address latch, beat counters, drop flag and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_araddr <= '0;
            r_cnt    <= '0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ICACHE_BRIDGE_WRAP_EN
            r_beat   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_araddr <= w_araddr_load;
                r_cnt    <= w_cnt_load;
                r_drop   <= 1'b0;
`ifdef ICACHE_BRIDGE_WRAP_EN
                r_beat   <= '0;
`endif
            end else if (w_rhs) begin
                // Power-of-two line: natural overflow gives the modulo wrap.
                r_cnt    <= r_cnt + IDX_W'(1);
`ifdef ICACHE_BRIDGE_WRAP_EN
                r_beat   <= r_beat + IDX_W'(1);
`endif
            end
            if ((r_state == ST_AR) && flush) begin
                r_drop <= 1'b1;
            end
            if (w_rhs && w_bad_beat) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule : icache_axi_rd_bridge
`default_nettype wire

// File: tb/tb_icache_axi_rd_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_icache_axi_rd_bridge                                      |
// | Description : Self-checking bench for icache_axi_rd_bridge: a vector table |
// |               for reset and a basic refill, parameterised burst sequences  |
// |               for the multi-cycle corner cases, and randomized bursts      |
// |               checked against a line-level reference model.               |
// | Options     : ICACHE_BRIDGE_WRAP_EN - expects critical-word-first WRAP.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_icache_axi_rd_bridge;

    localparam int         L     = 8;
    localparam logic [3:0] TB_ID = 4'h3;

    logic        clk, rst, flush;
    logic [31:0] c_araddr;
    logic        c_arvalid, c_arready;
    logic [31:0] c_rdata;
    logic        c_rvalid, c_rlast;
    logic [2:0]  c_rindex;
    logic        c_rready, err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int n_cmp = 0;
    int n_bad = 0;
    bit err_exp = 0;

    icache_axi_rd_bridge #(.LINE_WORDS(L), .AXI_ID(TB_ID)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .c_araddr(c_araddr), .c_arvalid(c_arvalid), .c_arready(c_arready),
        .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rlast(c_rlast),
        .c_rindex(c_rindex), .c_rready(c_rready), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rules for address and first word index.
    function automatic logic [31:0] exp_araddr(input logic [31:0] a);
`ifdef ICACHE_BRIDGE_WRAP_EN
        return {a[31:2], 2'b00};
`else
        return {a[31:5], 5'b0};
`endif
    endfunction

    function automatic int exp_start(input logic [31:0] a);
`ifdef ICACHE_BRIDGE_WRAP_EN
        return int'(a[4:2]);
`else
        return (a == 32'hFFFF_FFFF) ? 0 : 0;
`endif
    endfunction

`ifdef ICACHE_BRIDGE_WRAP_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; c_arvalid = 0; c_araddr = 0; c_rready = 0;
        arready = 0; rid = TB_ID; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        smp();
        chk("rst_c_arready", c_arready, 1);
        chk("rst_arvalid",   arvalid,   0);
        chk("rst_araddr",    araddr,    0);
        chk("rst_c_rvalid",  c_rvalid,  0);
        chk("rst_c_rlast",   c_rlast,   0);
        chk("rst_rready",    rready,    0);
        chk("rst_err",       err,       0);
        tick();
        rst = 0;
        err_exp = 0;
    endtask

    // One complete refill. Knobs select AR delay, flush point, injected
    // errors and cache/slave handshake patterns. The model: the cache sees
    // beats 0..n-1 of the line in order (n = L, or the flush point), each
    // with word index (start+j)%L and last only on j==L-1; the AXI side
    // always consumes L beats and the bridge is idle the cycle after.
    task automatic burst(input logic [31:0] addr, input int ar_dly,
                         input bit flush_ar, input int flush_beat,
                         input int err_beat, input int bad_rlast_beat,
                         input int bad_id_beat, input int rr_mode, input int rv_mode);
        int k, j, cyc, exp_cnt, st;
        bit flushed, do_flush, tog;
        logic [31:0] base, ea;
        base    = $urandom;
        ea      = exp_araddr(addr);
        st      = exp_start(addr);
        exp_cnt = flush_ar ? 0 : ((flush_beat >= 0) ? flush_beat : L);
        if (err_beat >= 0 || bad_rlast_beat >= 0 || bad_id_beat >= 0) err_exp = 1;

        c_arvalid = 1; c_araddr = addr; flush = 0;
        smp();
        chk("req_c_arready", c_arready, 1);
        tick();
        c_arvalid = 0; c_araddr = $urandom;

        for (int d = 0; d <= ar_dly; d++) begin
            arready = (d == ar_dly);
            flush   = flush_ar && (d == 0);
            smp();
            chk("ar_arvalid",  arvalid, 1);
            chk("ar_araddr",   araddr,  ea);
            chk("ar_arlen",    arlen,   L - 1);
            chk("ar_arburst",  arburst, EXP_BURST);
            chk("ar_c_arready", c_arready, 0);
            tick();
        end
        arready = 0; flush = 0;

        k = 0; j = 0; cyc = 0; flushed = flush_ar; tog = 1;
        while (k < L && cyc < 200) begin
            rvalid   = (rv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdata    = base + k;
            rresp    = (k == err_beat) ? 2'b10 : 2'b00;
            rid      = (k == bad_id_beat) ? ~TB_ID : TB_ID;
            rlast    = (k == L - 1) || (k == bad_rlast_beat);
            c_rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog      = !tog;
            do_flush = !flushed && (flush_beat >= 0) && (k == flush_beat);
            flush    = do_flush;
            smp();
            if (flushed || do_flush) chk("c_rvalid_suppressed", c_rvalid, 0);
            if (flushed) chk("drain_rready", rready, 1);
            else if (!do_flush) chk("r_rready", rready, c_rready);
            if (c_rvalid && c_rready) begin
                chk("beat_data",  c_rdata,  base + j);
                chk("beat_index", c_rindex, (st + j) % L);
                chk("beat_last",  c_rlast,  (j == L - 1));
                j++;
            end
            if (rvalid && rready) k++;
            if (do_flush) flushed = 1;
            tick();
            cyc++;
        end
        rvalid = 0; rlast = 0; rresp = 0; rid = TB_ID; flush = 0; c_rready = 0;
        if (k < L) chk("burst_timeout", k, L);
        smp();
        chk("idle_after_last", c_arready, 1);
        chk("beats_delivered", j, exp_cnt);
        chk("err_flag", err, err_exp);
        tick();
    endtask

    typedef struct {
        logic        c_arvalid;
        logic [31:0] c_araddr;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic        c_rready;
        logic        e_c_arready;
        logic        e_arvalid;
        logic        e_c_rvalid;
        logic        e_c_rlast;
        logic        e_rready;
        logic [2:0]  e_idx;
        logic [31:0] e_araddr;
        bit          chk_ar;
        bit          chk_beat;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [31:0] a0;
        idle_inputs();
        rst = 1;

        // ---- vector table: basic refill of the line holding 0x44 ----
        a0 = 32'h0000_0044;
        for (int i = 0; i < 11; i++) begin
            vt[i] = '{c_arvalid: 0, c_araddr: 0, arready: 0, rvalid: 0, rdata: 0,
                      rlast: 0, c_rready: 0, e_c_arready: 0, e_arvalid: 0,
                      e_c_rvalid: 0, e_c_rlast: 0, e_rready: 0, e_idx: 0,
                      e_araddr: 0, chk_ar: 0, chk_beat: 0};
        end
        vt[0].c_arvalid = 1; vt[0].c_araddr = a0; vt[0].e_c_arready = 1;
        vt[1].arready = 1; vt[1].e_arvalid = 1; vt[1].e_araddr = exp_araddr(a0); vt[1].chk_ar = 1;
        for (int b = 0; b < L; b++) begin
            vt[2 + b].rvalid     = 1;
            vt[2 + b].rdata      = 32'hD000_0000 + b;
            vt[2 + b].rlast      = (b == L - 1);
            vt[2 + b].c_rready   = 1;
            vt[2 + b].e_c_rvalid = 1;
            vt[2 + b].e_c_rlast  = (b == L - 1);
            vt[2 + b].e_rready   = 1;
            vt[2 + b].e_idx      = 3'((exp_start(a0) + b) % L);
            vt[2 + b].chk_beat   = 1;
        end
        vt[10].e_c_arready = 1;

        do_reset();
        for (int i = 0; i < 11; i++) begin
            c_arvalid = vt[i].c_arvalid; c_araddr = vt[i].c_araddr;
            arready = vt[i].arready; rvalid = vt[i].rvalid; rdata = vt[i].rdata;
            rlast = vt[i].rlast; c_rready = vt[i].c_rready;
            smp();
            chk("tv_c_arready", c_arready, vt[i].e_c_arready);
            chk("tv_arvalid",   arvalid,   vt[i].e_arvalid);
            chk("tv_c_rvalid",  c_rvalid,  vt[i].e_c_rvalid);
            chk("tv_c_rlast",   c_rlast,   vt[i].e_c_rlast);
            chk("tv_rready",    rready,    vt[i].e_rready);
            chk("tv_err",       err,       0);
            if (vt[i].chk_ar) begin
                chk("tv_araddr", araddr, vt[i].e_araddr);
                chk("tv_arlen",  arlen,  8'd7);
                chk("tv_arburst", arburst, EXP_BURST);
                chk("tv_arsize", arsize, 3'b010);
                chk("tv_arid",   arid,   TB_ID);
            end
            if (vt[i].chk_beat) begin
                chk("tv_c_rindex", c_rindex, vt[i].e_idx);
                chk("tv_c_rdata",  c_rdata,  vt[i].rdata);
            end
            tick();
        end
        idle_inputs();

        // ---- hand sequences ----
        // backpressure: c_rready toggling, arready after 3 cycles
        burst(32'h1000_0084, 3, 0, -1, -1, -1, -1, 1, 0);
        // flush after three delivered beats; five drained
        burst(32'h2000_0000, 0, 0, 3, -1, -1, -1, 0, 0);
        // flush in AR while arready low
        burst(32'h3000_0010, 2, 1, -1, -1, -1, -1, 0, 0);
        // flush coinciding with the last-beat handshake
        burst(32'h3100_001C, 0, 0, 7, -1, -1, -1, 0, 0);
        // sticky error: bad rresp on beat 3, then early rlast on beat 5
        burst(32'h4000_0020, 1, 0, -1, 3, -1, -1, 0, 0);
        burst(32'h4000_0040, 0, 0, -1, -1, 5, -1, 0, 0);
        do_reset();
        // rid mismatch detected while draining
        burst(32'h4100_0000, 0, 0, 2, -1, -1, 6, 0, 0);
        do_reset();
        // rst mid-burst returns to idle at once
        c_arvalid = 1; c_araddr = 32'h5000_0020; smp(); tick();
        c_arvalid = 0; arready = 1; smp(); tick();
        arready = 0; rvalid = 1; c_rready = 1;
        smp(); chk("midburst_c_rvalid", c_rvalid, 1); tick();
        do_reset();
        idle_inputs();
        burst(32'hA000_0018, 0, 0, -1, -1, -1, -1, 0, 0);

        // ---- randomized bursts vs line-level model ----
        for (int n = 0; n < 30; n++) begin
            int sel, fb;
            bit far;
            sel = $urandom_range(0, 9);
            far = (sel < 2);
            fb  = (sel >= 2 && sel < 4) ? $urandom_range(1, L - 1) : -1;
            burst($urandom, $urandom_range(0, 3), far, fb, -1, -1, -1, 2, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_icache_axi_rd_bridge
`default_nettype wire
